// File: rtl/csa_pkg.sv
// Constants and helpers shared by the 48-to-3x32 converter and its word consumers.
package csa_pkg;

  // A 48-bit sample splits into three 16-bit parts, so each upstream burst is three words.
  localparam int GROUP_WORDS = 3;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/csa_word_ram.sv
// Simple dual-port word RAM: synchronous write, registered read with hold when idle.
module csa_word_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The array is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/csa_out_word_buffer.sv
// Word FIFO between the 48-to-3x32 converter and the AXI register-read side.
module csa_out_word_buffer
  import csa_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  error_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  r_ready,
  output logic                  group_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  clear_err
);

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] GROUP_LEVEL  = (ADDR_WIDTH+1)'(GROUP_WORDS);
  localparam logic [ADDR_WIDTH:0] HEADROOM_MAX = (ADDR_WIDTH+1)'(DEPTH - GROUP_WORDS);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Handshake: a write is taken when wen is high and the registered level is below
  // DEPTH; a pop is taken when ren is high and the registered level is non-zero.
  // A taken pop returns its word on rdata with a one-cycle rvalid pulse on the next cycle.
  assign wr_ok = wen && (level != FULL_LEVEL);
  assign rd_ok = ren && (level != '0);

  assign error_full  = level > HEADROOM_MAX;
  assign r_ready     = level != '0;
  assign group_ready = level >= GROUP_LEVEL;

  csa_word_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata(wdata),
    .re(rd_ok),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      rvalid        <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        level <= level + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        level <= level - 1'b1;
      end
      // A new error in the same cycle as clear_err keeps the flag set.
      err_overflow  <= (err_overflow && !clear_err) || (wen && !wr_ok);
      err_underflow <= (err_underflow && !clear_err) || (ren && !rd_ok);
    end
  end

endmodule

// File: tb/tb_csa_out_word_buffer.sv
// Directed bench for csa_out_word_buffer: reset, bursts, headroom, overflow, underflow, wrap.
module tb_csa_out_word_buffer;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic [31:0] wdata;
  logic        error_full;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;
  logic        r_ready;
  logic        group_ready;
  logic [6:0]  level;
  logic        err_overflow;
  logic        err_underflow;
  logic        clear_err;

  int pass_cnt;
  int total_cnt;
  logic [31:0] exp_q[$];

  csa_out_word_buffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .wen(wen),
    .wdata(wdata),
    .error_full(error_full),
    .ren(ren),
    .rdata(rdata),
    .rvalid(rvalid),
    .r_ready(r_ready),
    .group_ready(group_ready),
    .level(level),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .clear_err(clear_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs set before the edge, outputs sampled 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    wen = 1'b1;
    wdata = d;
    cycle();
  endtask

  task automatic pop();
    ren = 1'b1;
    cycle();
  endtask

  task automatic push_pop(input logic [31:0] d);
    wen = 1'b1;
    wdata = d;
    ren = 1'b1;
    cycle();
  endtask

  task automatic clear_flags();
    clear_err = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    total_cnt++;
    if (level !== 7'd0 || r_ready !== 1'b0 || group_ready !== 1'b0 || error_full !== 1'b0) begin
      $display("FAIL reset_status: level=%0d r_ready=%b group_ready=%b error_full=%b, want 0/0/0/0",
               level, r_ready, group_ready, error_full);
    end else pass_cnt++;
    total_cnt++;
    if (rdata !== 32'd0 || rvalid !== 1'b0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      $display("FAIL reset_data: rdata=%h rvalid=%b ovf=%b unf=%b, want 0", rdata, rvalid,
               err_overflow, err_underflow);
    end else pass_cnt++;
    // Build up state: underflow flag, non-zero rdata, level 5.
    pop();
    for (int i = 0; i < 6; i++) push(32'hA000 + i);
    pop();
    total_cnt++;
    if (level !== 7'd5 || rvalid !== 1'b1 || rdata !== 32'hA000 || err_underflow !== 1'b1) begin
      $display("FAIL pre_reset: level=%0d rvalid=%b rdata=%h unf=%b, want 5/1/0000a000/1", level,
               rvalid, rdata, err_underflow);
    end else pass_cnt++;
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (level !== 7'd0 || r_ready !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'd0 ||
        err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
      $display("FAIL reset_async: level=%0d r_ready=%b rvalid=%b rdata=%h unf=%b ovf=%b, want all 0",
               level, r_ready, rvalid, rdata, err_underflow, err_overflow);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_burst_drain();
    logic [31:0] burst [3];
    burst[0] = 32'h1111;
    burst[1] = 32'h2222;
    burst[2] = 32'h3333;
    push(burst[0]);
    push(burst[1]);
    total_cnt++;
    if (level !== 7'd2 || group_ready !== 1'b0 || r_ready !== 1'b1) begin
      $display("FAIL burst_partial: level=%0d group_ready=%b r_ready=%b, want 2/0/1", level,
               group_ready, r_ready);
    end else pass_cnt++;
    push(burst[2]);
    total_cnt++;
    if (level !== 7'd3 || group_ready !== 1'b1) begin
      $display("FAIL burst_level: level=%0d group_ready=%b, want 3/1", level, group_ready);
    end else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      pop();
      total_cnt++;
      if (rvalid !== 1'b1 || rdata !== burst[i]) begin
        $display("FAIL burst_pop%0d: rvalid=%b rdata=%h, want 1/%h", i, rvalid, rdata, burst[i]);
      end else pass_cnt++;
    end
    cycle();
    total_cnt++;
    if (rvalid !== 1'b0 || level !== 7'd0 || rdata !== 32'h3333) begin
      $display("FAIL burst_after: rvalid=%b level=%0d rdata=%h, want 0/0/00003333", rvalid, level,
               rdata);
    end else pass_cnt++;
  endtask

  task automatic test_headroom();
    for (int i = 0; i < 61; i++) push(32'h5000 + i);
    total_cnt++;
    if (level !== 7'd61 || error_full !== 1'b0) begin
      $display("FAIL headroom_61: level=%0d error_full=%b, want 61/0", level, error_full);
    end else pass_cnt++;
    push(32'h5000 + 61);
    total_cnt++;
    if (level !== 7'd62 || error_full !== 1'b1) begin
      $display("FAIL headroom_62: level=%0d error_full=%b, want 62/1", level, error_full);
    end else pass_cnt++;
    pop();
    total_cnt++;
    if (level !== 7'd61 || error_full !== 1'b0 || rdata !== 32'h5000) begin
      $display("FAIL headroom_pop: level=%0d error_full=%b rdata=%h, want 61/0/00005000", level,
               error_full, rdata);
    end else pass_cnt++;
    for (int i = 0; i < 61; i++) pop();
    total_cnt++;
    if (level !== 7'd0 || rdata !== 32'h503D) begin
      $display("FAIL headroom_drain: level=%0d rdata=%h, want 0/0000503d", level, rdata);
    end else pass_cnt++;
  endtask

  task automatic test_overflow();
    int bad;
    for (int i = 0; i < 64; i++) push(32'h100 + i);
    total_cnt++;
    if (level !== 7'd64 || error_full !== 1'b1 || err_overflow !== 1'b0) begin
      $display("FAIL ovf_full: level=%0d error_full=%b ovf=%b, want 64/1/0", level, error_full,
               err_overflow);
    end else pass_cnt++;
    push(32'hDEAD);
    total_cnt++;
    if (level !== 7'd64 || err_overflow !== 1'b1) begin
      $display("FAIL ovf_drop: level=%0d ovf=%b, want 64/1", level, err_overflow);
    end else pass_cnt++;
    clear_flags();
    push_pop(32'hBEEF);
    total_cnt++;
    if (level !== 7'd63 || rvalid !== 1'b1 || rdata !== 32'h100 || err_overflow !== 1'b1) begin
      $display("FAIL ovf_full_both: level=%0d rvalid=%b rdata=%h ovf=%b, want 63/1/00000100/1",
               level, rvalid, rdata, err_overflow);
    end else pass_cnt++;
    bad = 0;
    for (int i = 1; i < 64; i++) begin
      pop();
      if (rvalid !== 1'b1 || rdata !== 32'h100 + i) bad++;
    end
    total_cnt++;
    if (bad != 0 || level !== 7'd0) begin
      $display("FAIL ovf_drain: bad_words=%0d level=%0d, want 0/0", bad, level);
    end else pass_cnt++;
    clear_flags();
    total_cnt++;
    if (err_overflow !== 1'b0) begin
      $display("FAIL ovf_clear: ovf=%b, want 0", err_overflow);
    end else pass_cnt++;
  endtask

  task automatic test_underflow_simul();
    int bad;
    pop();
    total_cnt++;
    if (err_underflow !== 1'b1 || rvalid !== 1'b0 || level !== 7'd0) begin
      $display("FAIL unf_empty: unf=%b rvalid=%b level=%0d, want 1/0/0", err_underflow, rvalid, level);
    end else pass_cnt++;
    // Clear and new error in the same cycle: set wins.
    clear_err = 1'b1;
    pop();
    total_cnt++;
    if (err_underflow !== 1'b1) begin
      $display("FAIL unf_set_wins: unf=%b, want 1", err_underflow);
    end else pass_cnt++;
    clear_flags();
    push_pop(32'hA5);
    total_cnt++;
    if (level !== 7'd1 || rvalid !== 1'b0 || err_underflow !== 1'b1) begin
      $display("FAIL empty_both: level=%0d rvalid=%b unf=%b, want 1/0/1", level, rvalid, err_underflow);
    end else pass_cnt++;
    pop();
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'hA5 || level !== 7'd0) begin
      $display("FAIL empty_both_pop: rvalid=%b rdata=%h level=%0d, want 1/000000a5/0", rvalid, rdata,
               level);
    end else pass_cnt++;
    clear_flags();
    for (int i = 0; i < 10; i++) push(32'h200 + i);
    push_pop(32'h20A);
    total_cnt++;
    if (level !== 7'd10 || rvalid !== 1'b1 || rdata !== 32'h200) begin
      $display("FAIL mid_both: level=%0d rvalid=%b rdata=%h, want 10/1/00000200", level, rvalid, rdata);
    end else pass_cnt++;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      pop();
      if (rvalid !== 1'b1 || rdata !== 32'h200 + i) bad++;
    end
    total_cnt++;
    if (bad != 0 || level !== 7'd0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      $display("FAIL mid_drain: bad=%0d level=%0d ovf=%b unf=%b, want 0/0/0/0", bad, level,
               err_overflow, err_underflow);
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    int sent;
    int rcvd;
    int mlevel;
    int bad;
    int cyc;
    logic [31:0] exp;
    sent = 0;
    rcvd = 0;
    mlevel = 0;
    bad = 0;
    cyc = 0;
    exp_q.delete();
    while ((sent < 200 || mlevel > 0) && cyc < 2000) begin
      wen = (sent < 200) && (mlevel < 40) && (cyc % 4 != 3);
      wdata = sent;
      ren = (sent < 200) ? ((mlevel > 2) && (cyc % 3 != 0)) : (mlevel > 0);
      if (wen) begin
        exp_q.push_back(sent);
        sent++;
      end
      mlevel = mlevel + (wen ? 1 : 0) - (ren ? 1 : 0);
      cycle();
      cyc++;
      if (level !== 7'(mlevel)) bad++;
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) bad++;
        else begin
          exp = exp_q.pop_front();
          if (rdata !== exp) bad++;
          rcvd++;
        end
      end
    end
    total_cnt++;
    if (bad != 0 || rcvd != 200 || cyc >= 2000) begin
      $display("FAIL wrap_stream: bad=%0d received=%0d cycles=%0d, want 0/200/<2000", bad, rcvd, cyc);
    end else pass_cnt++;
    total_cnt++;
    if (level !== 7'd0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      $display("FAIL wrap_end: level=%0d ovf=%b unf=%b, want 0/0/0", level, err_overflow,
               err_underflow);
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    wen = 1'b0;
    wdata = '0;
    ren = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    test_reset();
    test_burst_drain();
    test_headroom();
    test_overflow();
    test_underflow_simul();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
